scoreboard_regfile: RTL and testbench

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

---
 rtl/regfile_pkg.sv | 8 +
 rtl/rf_read_port.sv | 46 ++++
 rtl/scoreboard_regfile.sv | 80 ++++++++
 tb/tb_scoreboard_regfile.sv | 137 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: default register-file sizes and the address-width helper shared by the scoreboard register file
package regfile_pkg;
  localparam int NREG_DEF  = 32;
  localparam int WIDTH_DEF = 32;
  function automatic int aw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port (array mux, zero-reg force, optional write forwarding under RF_BYPASS_EN)
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = aw_f(NREG)
) (
  input  logic [AW-1:0]        addr_i,
  input  logic [WIDTH-1:0]     mem_i [NREG],
  input  logic [NREG-1:0]      busy_i,
`ifdef RF_BYPASS_EN
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*AW-1:0]    wr_addr_i,
  input  logic [NWR*WIDTH-1:0] wr_data_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_addr_i,
`endif
  output logic [WIDTH-1:0]     data_o,
  output logic                 rdy_o
);
`ifdef RF_BYPASS_EN
  logic hit;
`endif
  // select array entry, forward any same-cycle write (highest port last), then force hardwired zero
  always_comb begin
    data_o = mem_i[addr_i];
    rdy_o  = ~busy_i[addr_i];
`ifdef RF_BYPASS_EN
    hit = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == addr_i) begin
        data_o = wr_data_i[j*WIDTH +: WIDTH];
        hit    = 1'b1;
      end
    end
    if (hit) rdy_o = !(iss_en_i && iss_addr_i == addr_i);
`endif
    if (ZERO_REG != 0 && addr_i == '0) begin
      data_o = '0;
      rdy_o  = 1'b1;
    end
  end
endmodule

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: multi-port register file with per-register busy bits for hazard tracking; RF_BYPASS_EN adds write-to-read forwarding
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = aw_f(NREG)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_rdy,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ok,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data
);
  logic [WIDTH-1:0] mem_q [NREG];
  logic [WIDTH-1:0] mem_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  // writes in port order so the higher port wins; a new reservation overrides a clearing write
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        mem_d[wr_addr[j*AW +: AW]]  = wr_data[j*WIDTH +: WIDTH];
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en) busy_d[iss_addr] = 1'b1;
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end
  // state update; reset clears data and busy bits regardless of concurrent writes/issues
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end
  // WAW check for the issuing instruction, optionally seeing a same-cycle clearing write
  always_comb begin
    iss_ok = ~busy_q[iss_addr];
`ifdef RF_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == iss_addr) iss_ok = 1'b1;
`endif
    if (ZERO_REG != 0 && iss_addr == '0) iss_ok = 1'b1;
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_read_port #(
      .NREG(NREG), .WIDTH(WIDTH), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) u_rp (
      .addr_i    (rd_addr[i*AW +: AW]),
      .mem_i     (mem_q),
      .busy_i    (busy_q),
`ifdef RF_BYPASS_EN
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .iss_en_i  (iss_en),
      .iss_addr_i(iss_addr),
`endif
      .data_o    (rd_data[i*WIDTH +: WIDTH]),
      .rdy_o     (rd_rdy[i])
    );
  end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb_scoreboard_regfile: directed scoreboard bench for scoreboard_regfile (ZERO_REG=1 and ZERO_REG=0 instances, NWR=2); honours RF_BYPASS_EN
module tb_scoreboard_regfile;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    string       name;
    logic [31:0] ad0;
    logic        ar0;
    logic [31:0] ad1;
    logic        aok;
    logic [31:0] bd0;
    logic        br0;
    logic        bok;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  rd_addr;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_rdy, b_rd_rdy;
  logic        a_iss_ok, b_iss_ok;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  scoreboard_regfile #(.NRD(2), .NWR(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_rdy(a_rd_rdy),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(a_iss_ok),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  scoreboard_regfile #(.NRD(2), .NWR(2), .ZERO_REG(0)) u_b (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_rdy(b_rd_rdy),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(b_iss_ok),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", n, f, act, exp);
    end
  endtask

  // monitor: outputs are combinational, so check mid-cycle on the falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "a_data0", a_rd_data[31:0], e.ad0);
      cmp(e.name, "a_rdy0", {31'd0, a_rd_rdy[0]}, {31'd0, e.ar0});
      cmp(e.name, "a_data1", a_rd_data[63:32], e.ad1);
      cmp(e.name, "a_iss_ok", {31'd0, a_iss_ok}, {31'd0, e.aok});
      cmp(e.name, "b_data0", b_rd_data[31:0], e.bd0);
      cmp(e.name, "b_rdy0", {31'd0, b_rd_rdy[0]}, {31'd0, e.br0});
      cmp(e.name, "b_iss_ok", {31'd0, b_iss_ok}, {31'd0, e.bok});
    end
  end

  task automatic drive(input logic rn, input logic [4:0] r0, input logic [4:0] r1,
                       input logic ie, input logic [4:0] ia, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1);
    rstn = rn; rd_addr = {r1, r0}; iss_en = ie; iss_addr = ia;
    wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
  endtask

  task automatic cyc(input string n, input logic [31:0] ad0, input logic ar0, input logic [31:0] ad1,
                     input logic aok, input logic [31:0] bd0, input logic br0, input logic bok);
    exp_t e;
    e.name = n; e.ad0 = ad0; e.ar0 = ar0; e.ad1 = ad1; e.aok = aok;
    e.bd0 = bd0; e.br0 = br0; e.bok = bok;
    q.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic idle;
    @(posedge clk); #2;
  endtask

  initial begin
    drive(1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 2'b11, 5'd9, 32'h1111, 5'd9, 32'h2222);
    idle();
    idle();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'(i), 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      cyc($sformatf("rst_r%0d", i), 32'd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
    end
    drive(1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("iss_r5", 32'd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
    drive(1'b1, 5'd5, 5'd3, 1'b0, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("busy_r5", 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 5'd5, 5'd3, 1'b0, 5'd5, 2'b01, 5'd5, 32'h7, 5'd0, 32'd0);
    cyc("wr_r5", BYP ? 32'h7 : 32'h0, BYP, 32'd0, BYP, BYP ? 32'h7 : 32'h0, BYP, BYP);
    drive(1'b1, 5'd5, 5'd3, 1'b0, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("rd_r5", 32'h7, 1'b1, 32'd0, 1'b1, 32'h7, 1'b1, 1'b1);
    drive(1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 2'b01, 5'd3, 32'hDEAD_BEEF, 5'd0, 32'd0);
    cyc("wr_r3", BYP ? 32'hDEAD_BEEF : 32'h0, 1'b1, BYP ? 32'hDEAD_BEEF : 32'h0, 1'b1,
        BYP ? 32'hDEAD_BEEF : 32'h0, 1'b1, 1'b1);
    drive(1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("rd_r3", 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    drive(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 2'b01, 5'd0, 32'd15, 5'd0, 32'd0);
    cyc("wr_iss_r0", 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, BYP ? 32'd15 : 32'd0, 1'b1 ^ BYP, 1'b1);
    drive(1'b1, 5'd0, 5'd3, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("rd_r0", 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'd15, 1'b0, 1'b0);
    drive(1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 2'b11, 5'd9, 32'd1, 5'd9, 32'd2);
    cyc("dual_wr_r9", BYP ? 32'd2 : 32'd0, 1'b1 ^ BYP, 32'hDEAD_BEEF, 1'b1,
        BYP ? 32'd2 : 32'd0, 1'b1 ^ BYP, 1'b1);
    drive(1'b1, 5'd9, 5'd3, 1'b0, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("rd_r9", 32'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd2, 1'b0, 1'b0);
    drive(1'b0, 5'd9, 5'd3, 1'b1, 5'd7, 2'b11, 5'd7, 32'h55, 5'd9, 32'h66);
    idle();
    drive(1'b1, 5'd9, 5'd3, 1'b0, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("rst2_r9", 32'd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
    drive(1'b1, 5'd7, 5'd5, 1'b0, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("rst2_r7", 32'd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
    drive(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    cyc("rst2_r0", 32'd0, 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
    idle();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
